mseq10: RTL and testbench

MSEQ10 -- requirements
Module: mseq10

---
 rtl/mseq10_pkg.sv | 22 ++
 rtl/mseq_stack.sv | 65 ++++++
 rtl/mseq10.sv | 106 ++++++++++
 tb/tb_mseq10.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mseq10_pkg.sv
// Shared definitions for the mseq10 microprogram sequencer: opcode encodings and the
// condition-pass helper used by the RTL and its benches.
package mseq10_pkg;

  typedef enum logic [3:0] {
    OpJz   = 4'd0,
    OpCjs  = 4'd1,
    OpJmap = 4'd2,
    OpCjp  = 4'd3,
    OpPush = 4'd4,
    OpLdct = 4'd5,
    OpRpct = 4'd6,
    OpCrtn = 4'd7,
    OpCont = 4'd8
  } op_e;

  // Both inputs are active-low; a disabled condition always passes.
  function automatic logic cond_pass(input logic cc_n, input logic ccen_n);
    return ccen_n | ~cc_n;
  endfunction

endpackage

// File: rtl/mseq_stack.sv
// Return-address stack for mseq10: push/pop/clear with saturating top entry on overflow and
// zero readout when empty.
module mseq_stack #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic             full_
);

  localparam int unsigned SpW = $clog2(DEPTH + 1);

  logic [SpW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             is_full;

  assign is_full = (sp_q == SpW'(DEPTH));
  assign full_   = ~is_full;

  // Empty stack reads as zero.
  always_comb begin
    tos = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (sp_q == SpW'(k + 1)) tos = mem_q[k];
    end
  end

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (clear) begin
      sp_d = '0;
      for (int k = 0; k < int'(DEPTH); k++) mem_d[k] = '0;
    end else if (push) begin
      if (is_full) begin
        mem_d[DEPTH-1] = din;
      end else begin
        for (int k = 0; k < int'(DEPTH); k++) begin
          if (sp_q == SpW'(k)) mem_d[k] = din;
        end
        sp_d = sp_q + 1'b1;
      end
    end else if (pop && (sp_q != '0)) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sp_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) mem_q[k] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/mseq10.sv
// mseq10: microprogram sequencer with uPC, loop counter R and a return stack; the next
// address y is combinational from the instruction, d, the condition and registered state.
module mseq10
  import mseq10_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [3:0]       i,
  input  logic             cc_,
  input  logic             ccen_,
  input  logic             ci,
  input  logic             rld_,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y,
  output logic             map_,
  output logic             pl_,
  output logic             full_
);

  logic [WIDTH-1:0] upc_q, upc_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] tos;
  logic             pass;
  logic             push, pop, clear;

  assign pass = cond_pass(cc_, ccen_);

  always_comb begin
    y     = upc_q;
    map_  = 1'b1;
    pl_   = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
    r_d   = r_q;
    case (i)
      OpJz: begin
        y     = '0;
        clear = 1'b1;
      end
      OpCjs: begin
        if (pass) begin
          y    = d;
          push = 1'b1;
        end
      end
      OpJmap: begin
        y    = d;
        map_ = 1'b0;
        pl_  = 1'b1;
      end
      OpCjp: begin
        if (pass) y = d;
      end
      OpPush: begin
        push = 1'b1;
        if (pass) r_d = d;
      end
      OpLdct: r_d = d;
      OpRpct: begin
        if (r_q != '0) begin
          y   = d;
          r_d = r_q - 1'b1;
        end
      end
      OpCrtn: begin
        if (pass) begin
          y   = tos;
          pop = 1'b1;
        end
      end
      default: ;
    endcase
    // Direct counter load wins over decrement and conditional load.
    if (!rld_) r_d = d;
    upc_d = y + WIDTH'(ci);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      upc_q <= '0;
      r_q   <= '0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
    end
  end

  mseq_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_  (rst_),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (upc_q),
    .tos   (tos),
    .full_ (full_)
  );

endmodule

// File: tb/tb_mseq10.sv
// Bench for mseq10: directed scenarios then randomized instructions, all against a
// queue-based reference model of the sequencer.
module tb_mseq10;
  import mseq10_pkg::*;

  localparam int unsigned DEPTH = 5;

  logic       clk, rst_, cc_, ccen_, ci, rld_;
  logic [3:0] i;
  logic [9:0] d, y;
  logic       map_, pl_, full_;

  int checks = 0;
  int errors = 0;

  int unsigned m_upc;
  int unsigned m_r;
  int unsigned m_stk[$];
  logic [9:0]  last_y;

  mseq10 #(
    .WIDTH (10),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_  (rst_),
    .i     (i),
    .cc_   (cc_),
    .ccen_ (ccen_),
    .ci    (ci),
    .rld_  (rld_),
    .d     (d),
    .y     (y),
    .map_  (map_),
    .pl_   (pl_),
    .full_ (full_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_upc = 0;
    m_r   = 0;
    m_stk.delete();
  endtask

  task automatic model_push(input int unsigned v);
    if (m_stk.size() < DEPTH) m_stk.push_back(v);
    else m_stk[DEPTH-1] = v;
  endtask

  // Called at posedge+1; drives one instruction, checks outputs, then crosses one edge.
  task automatic step(input logic [3:0] op, input logic [9:0] dd, input logic cc,
                      input logic ccen, input logic cin, input logic rld);
    int unsigned ey, nr, tos;
    logic        pass, em, ep, ef;
    i = op; d = dd; cc_ = cc; ccen_ = ccen; ci = cin; rld_ = rld;
    pass = ccen | ~cc;
    tos  = (m_stk.size() != 0) ? m_stk[m_stk.size()-1] : 0;
    ef   = (m_stk.size() == DEPTH) ? 1'b0 : 1'b1;
    ey = m_upc; em = 1'b1; ep = 1'b0; nr = m_r;
    case (op)
      4'd0: begin ey = 0; m_stk.delete(); end
      4'd1: if (pass) begin ey = dd; model_push(m_upc); end
      4'd2: begin ey = dd; em = 1'b0; ep = 1'b1; end
      4'd3: if (pass) ey = dd;
      4'd4: begin model_push(m_upc); if (pass) nr = dd; end
      4'd5: nr = dd;
      4'd6: if (m_r != 0) begin ey = dd; nr = m_r - 1; end
      4'd7: if (pass) begin ey = tos; if (m_stk.size() != 0) void'(m_stk.pop_back()); end
      default: ;
    endcase
    if (!rld) nr = dd;
    #2;
    chk("y", y, ey);
    chk("map_", map_, em);
    chk("pl_", pl_, ep);
    chk("full_", full_, ef);
    last_y = y;
    @(posedge clk);
    #1;
    m_upc = (ey + cin) % 1024;
    m_r   = nr;
  endtask

  // Asserts reset between edges with current inputs held, checks cleared state, releases.
  task automatic do_reset();
    logic [9:0] ey;
    logic       pass;
    rst_ = 1'b0;
    #2;
    pass = ccen_ | ~cc_;
    ey = ((i == 4'd2) || (((i == 4'd1) || (i == 4'd3)) && pass)) ? d : 10'd0;
    chk("rst_y", y, ey);
    chk("rst_full_", full_, 1);
    chk("rst_upc", dut.upc_q, 0);
    chk("rst_r", dut.r_q, 0);
    chk("rst_sp", dut.u_stack.sp_q, 0);
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    model_reset();
  endtask

  initial begin
    int exp_ret[6];
    exp_ret = '{5, 3, 2, 1, 0, 0};
    rst_ = 1'b0; i = OpCont; d = '0; cc_ = 1'b1; ccen_ = 1'b1; ci = 1'b1; rld_ = 1'b1;
    model_reset();
    #3;
    chk("por_y", y, 0);
    chk("por_full_", full_, 1);
    i = OpJmap; d = 10'h155;
    #1;
    chk("por_jmap_y", y, 10'h155);
    chk("por_map_", map_, 0);
    i = OpCont;
    @(posedge clk);
    #1;
    rst_ = 1'b1;

    // Sequential count from reset.
    for (int k = 0; k < 5; k++) begin
      step(OpCont, 10'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("count", last_y, k);
    end

    // Subroutine call and return.
    step(OpCjp, 10'h010, 1'b0, 1'b0, 1'b1, 1'b1);
    step(OpCjs, 10'h200, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("cjs_y", last_y, 10'h200);
    step(OpCont, 10'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("cont_y", last_y, 10'h201);
    step(OpCrtn, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("crtn_y", last_y, 10'h011);
    chk("crtn_sp", dut.u_stack.sp_q, 0);

    // Counted loop.
    step(OpLdct, 10'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(OpRpct, 10'h050, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("rpct_loop", last_y, 10'h050);
    end
    step(OpRpct, 10'h050, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rpct_exit", last_y, 10'h051);
    chk("rpct_r", dut.r_q, 0);

    // Stack overflow and underflow from power-up state.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(OpPush, 10'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      if (k == 3) chk("full_4", full_, 1);
      if (k == 4) chk("full_5", full_, 0);
    end
    chk("full_6", full_, 0);
    for (int k = 0; k < 6; k++) begin
      step(OpCrtn, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("ret", last_y, exp_ret[k]);
    end

    // Reset in the middle of a loop with a full stack.
    for (int k = 0; k < 5; k++) step(OpPush, 10'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(OpLdct, 10'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    step(OpRpct, 10'h020, 1'b1, 1'b1, 1'b1, 1'b1);
    step(OpRpct, 10'h020, 1'b1, 1'b1, 1'b1, 1'b1);
    do_reset();
    step(OpCont, 10'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("post_rst_y", last_y, 0);

    // Wrap and map.
    step(OpCjp, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b1);
    step(OpCont, 10'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("wrap_a", last_y, 10'h3FF);
    step(OpCont, 10'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("wrap_b", last_y, 10'h000);
    step(OpJmap, 10'h123, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("jmap_y", last_y, 10'h123);

    // Randomized instruction stream.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        step(4'($urandom_range(0, 15)), 10'($urandom_range(0, 1023)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
